com_fifo_ctrl: RTL and testbench

//  Device-bus responder for the UART, replacing the unbuffered serial_ctrl path.

---
 rtl/com_fifo_ctrl_pkg.sv | 10 +
 rtl/com_fifo_ctrl_if.sv | 23 ++
 rtl/com_fifo_ctrl_sync_fifo.sv | 36 +++
 rtl/com_fifo_ctrl.sv | 82 ++++++++
 tb/tb_com_fifo_ctrl.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/com_fifo_ctrl_pkg.sv
// com_fifo_ctrl_pkg: register offsets, STAT bit positions and TX FSM states
package com_fifo_ctrl_pkg;
  typedef enum logic [1:0] {REG_DATA, REG_STAT, REG_IER, REG_COUNT} reg_e;
  localparam int STAT_RX_VALID = 0;
  localparam int STAT_RX_FULL = 1;
  localparam int STAT_TX_EMPTY = 2;
  localparam int STAT_TX_FULL = 3;
  localparam int STAT_OVERRUN = 4;
  typedef enum logic [1:0] {IDLE, START, WAIT_HI, WAIT_LO} tx_state_e;
endpackage

// File: rtl/com_fifo_ctrl_if.sv
// com_fifo_ctrl_if: device-bus request/response plus UART PHY handshake
interface com_fifo_ctrl_if;
  logic enable;
  logic read_enable;
  logic [1:0] addr;
  logic [31:0] data_save;
  logic [31:0] data_load;
  logic busy;
  logic intr;
  logic rxd_ready;
  logic [7:0] rxd_data;
  logic txd_busy;
  logic txd_start;
  logic [7:0] txd_data;
  modport slave (
    input enable, read_enable, addr, data_save, rxd_ready, rxd_data, txd_busy,
    output data_load, busy, intr, txd_start, txd_data
  );
  modport master (
    output enable, read_enable, addr, data_save, rxd_ready, rxd_data, txd_busy,
    input data_load, busy, intr, txd_start, txd_data
  );
endinterface

// File: rtl/com_fifo_ctrl_sync_fifo.sv
// sync_fifo: single-clock FIFO; push while full is accepted only alongside a pop
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  logic pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] head,
  output logic full,
  output logic empty,
  output logic [DEPTH_LOG2:0] count
);
  logic [WIDTH-1:0] mem [2**DEPTH_LOG2];
  logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  assign do_pop = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign empty = count == '0;
  assign full = count[DEPTH_LOG2];
  assign head = mem[rd_ptr];
  always_ff @(posedge clk)
    if (do_push) mem[wr_ptr] <= din;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      wr_ptr <= wr_ptr + DEPTH_LOG2'(do_push);
      rd_ptr <= rd_ptr + DEPTH_LOG2'(do_pop);
      count <= count + (DEPTH_LOG2+1)'(do_push) - (DEPTH_LOG2+1)'(do_pop);
    end
endmodule

// File: rtl/com_fifo_ctrl.sv
// com_fifo_ctrl: UART bus responder with RX/TX FIFOs, status, interrupt and TX launcher
module com_fifo_ctrl
  import com_fifo_ctrl_pkg::*;
#(
  parameter int DEPTH_LOG2 = 4
) (
  input logic clk,
  input logic rst,
  com_fifo_ctrl_if.slave bus
);
  logic [7:0] rx_head, tx_head, txd_data_r;
  logic rx_full, rx_empty, tx_full, tx_empty;
  logic [DEPTH_LOG2:0] rx_count, tx_count;
  logic wr_data, busy, acc, rd, wr, rx_pop, tx_pop, tx_push;
  logic [1:0] ier;
  logic overrun, txd_start_r, intr_r;
  logic [31:0] stat, count_word;
  logic unused;
  reg_e sel;
  tx_state_e state, state_n;
  assign sel = reg_e'(bus.addr);
  assign tx_pop = state == IDLE & ~tx_empty & ~bus.txd_busy;
  assign wr_data = bus.enable & ~bus.read_enable & sel == REG_DATA;
  // a launch in the same cycle frees a slot, so a full FIFO need not stall
  assign busy = wr_data & tx_full & ~tx_pop;
  assign acc = bus.enable & ~busy;
  assign rd = acc & bus.read_enable;
  assign wr = acc & ~bus.read_enable;
  assign rx_pop = rd & sel == REG_DATA;
  assign tx_push = wr & sel == REG_DATA;
  assign unused = ^bus.data_save[31:8];
  sync_fifo #(.WIDTH(8), .DEPTH_LOG2(DEPTH_LOG2)) u_rx (
    .clk(clk), .rst(rst), .push(bus.rxd_ready), .pop(rx_pop), .din(bus.rxd_data),
    .head(rx_head), .full(rx_full), .empty(rx_empty), .count(rx_count)
  );
  sync_fifo #(.WIDTH(8), .DEPTH_LOG2(DEPTH_LOG2)) u_tx (
    .clk(clk), .rst(rst), .push(tx_push), .pop(tx_pop), .din(bus.data_save[7:0]),
    .head(tx_head), .full(tx_full), .empty(tx_empty), .count(tx_count)
  );
  always_comb begin
    stat = '0;
    stat[STAT_RX_VALID] = ~rx_empty;
    stat[STAT_RX_FULL] = rx_full;
    stat[STAT_TX_EMPTY] = tx_empty;
    stat[STAT_TX_FULL] = tx_full;
    stat[STAT_OVERRUN] = overrun;
    count_word = {16'(rx_count), 16'(tx_count)};
    bus.data_load = ~rd ? 32'h0 :
                    sel == REG_DATA ? {24'h0, rx_empty ? 8'h00 : rx_head} :
                    sel == REG_STAT ? stat :
                    sel == REG_IER ? {30'h0, ier} : count_word;
  end
  always_comb begin
    state_n = state;
    state_n = state == IDLE ? (tx_pop ? START : IDLE) :
              state == START ? WAIT_HI :
              state == WAIT_HI ? (bus.txd_busy ? WAIT_LO : WAIT_HI) :
              (bus.txd_busy ? WAIT_LO : IDLE);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      ier <= '0;
      overrun <= 1'b0;
      txd_start_r <= 1'b0;
      txd_data_r <= '0;
      intr_r <= 1'b0;
    end else begin
      ier <= (wr & sel == REG_IER) ? bus.data_save[1:0] : ier;
      // a fresh overrun beats the clear-on-read of STAT
      overrun <= (bus.rxd_ready & rx_full & ~rx_pop) | (overrun & ~(rd & sel == REG_STAT));
      txd_start_r <= tx_pop;
      txd_data_r <= tx_pop ? tx_head : txd_data_r;
      intr_r <= (ier[0] & ~rx_empty) | (ier[1] & tx_empty & state == IDLE);
    end
  assign bus.busy = busy;
  assign bus.txd_start = txd_start_r;
  assign bus.txd_data = txd_data_r;
  assign bus.intr = intr_r;
endmodule

// File: tb/tb_com_fifo_ctrl.sv
// tb_com_fifo_ctrl: directed scenario tests with a simple transmitter model
module tb_com_fifo_ctrl;
  logic clk = 0;
  logic rst = 1;
  com_fifo_ctrl_if bus();
  com_fifo_ctrl #(.DEPTH_LOG2(4)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  int n_pass = 0;
  int n_chk = 0;
  logic stall = 0;
  logic pend = 0;
  int busy_cnt = 0;
  int start_while_busy = 0;
  logic [7:0] txq[$];
  assign bus.txd_busy = stall | (busy_cnt != 0);
  // transmitter raises busy one cycle after seeing start and holds it 40 cycles
  always @(posedge clk) begin
    if (bus.txd_start) begin
      txq.push_back(bus.txd_data);
      if (bus.txd_busy) start_while_busy++;
    end
    pend <= bus.txd_start;
    busy_cnt <= pend ? 40 : (busy_cnt > 0 ? busy_cnt - 1 : 0);
  end
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic rx_pulse(input logic [7:0] b);
    @(negedge clk);
    bus.rxd_ready = 1;
    bus.rxd_data = b;
    @(posedge clk);
    #1 bus.rxd_ready = 0;
  endtask
  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    @(negedge clk);
    bus.enable = 1;
    bus.read_enable = 1;
    bus.addr = a;
    #1 d = bus.data_load;
    @(posedge clk);
    #1 bus.enable = 0;
  endtask
  task automatic wr(input logic [1:0] a, input logic [31:0] v, output int waits);
    @(negedge clk);
    bus.enable = 1;
    bus.read_enable = 0;
    bus.addr = a;
    bus.data_save = v;
    waits = 0;
    #1;
    while (bus.busy && waits < 200) begin
      @(negedge clk);
      #1 waits++;
    end
    @(posedge clk);
    #1 bus.enable = 0;
  endtask
  task automatic test_reset;
    logic [31:0] d;
    int w;
    cyc(2);
    rst = 0;
    rx_pulse(8'h99);
    wr(2'd2, 32'h3, w);
    cyc(2);
    n_chk++; if (bus.intr !== 1'b1) $display("FAIL pre_reset_intr: got %b want 1", bus.intr); else n_pass++;
    @(posedge clk);
    #3 rst = 1;
    #1;
    n_chk++; if (bus.intr !== 1'b0) $display("FAIL reset_intr: got %b want 0", bus.intr); else n_pass++;
    n_chk++; if ({bus.busy, bus.txd_start} !== 2'b00) $display("FAIL reset_busy_start: got %b want 00", {bus.busy, bus.txd_start}); else n_pass++;
    n_chk++; if ({bus.txd_data, bus.data_load} !== 40'h0) $display("FAIL reset_data: got %h want 0", {bus.txd_data, bus.data_load}); else n_pass++;
    @(posedge clk);
    #1 rst = 0;
    rd(2'd1, d);
    n_chk++; if (d !== 32'h4) $display("FAIL reset_stat: got %h want 00000004", d); else n_pass++;
    rd(2'd2, d);
    n_chk++; if (d !== 32'h0) $display("FAIL reset_ier: got %h want 00000000", d); else n_pass++;
    rd(2'd3, d);
    n_chk++; if (d !== 32'h0) $display("FAIL reset_count: got %h want 00000000", d); else n_pass++;
  endtask
  task automatic test_rx;
    logic [31:0] d;
    rx_pulse(8'h41);
    rx_pulse(8'h42);
    rd(2'd1, d);
    n_chk++; if (d !== 32'h5) $display("FAIL rx_stat: got %h want 00000005", d); else n_pass++;
    rd(2'd3, d);
    n_chk++; if (d !== 32'h00020000) $display("FAIL rx_count: got %h want 00020000", d); else n_pass++;
    rd(2'd0, d);
    n_chk++; if (d !== 32'h41) $display("FAIL rx_data0: got %h want 00000041", d); else n_pass++;
    rd(2'd0, d);
    n_chk++; if (d !== 32'h42) $display("FAIL rx_data1: got %h want 00000042", d); else n_pass++;
    rd(2'd0, d);
    n_chk++; if (d !== 32'h0) $display("FAIL rx_empty_read: got %h want 00000000", d); else n_pass++;
    rd(2'd1, d);
    n_chk++; if (d !== 32'h4) $display("FAIL rx_stat_drained: got %h want 00000004", d); else n_pass++;
  endtask
  task automatic test_overrun;
    logic [31:0] d;
    for (int i = 0; i < 17; i++) rx_pulse(8'h10 + 8'(i));
    rd(2'd1, d);
    n_chk++; if (d !== 32'h17) $display("FAIL ovr_stat: got %h want 00000017", d); else n_pass++;
    rd(2'd1, d);
    n_chk++; if (d !== 32'h07) $display("FAIL ovr_cleared: got %h want 00000007", d); else n_pass++;
    rd(2'd3, d);
    n_chk++; if (d !== 32'h00100000) $display("FAIL ovr_count: got %h want 00100000", d); else n_pass++;
    rd(2'd0, d);
    n_chk++; if (d !== 32'h10) $display("FAIL ovr_first: got %h want 00000010", d); else n_pass++;
    for (int i = 0; i < 15; i++) rd(2'd0, d);
    n_chk++; if (d !== 32'h1F) $display("FAIL ovr_last: got %h want 0000001f", d); else n_pass++;
    rd(2'd1, d);
    n_chk++; if (d !== 32'h4) $display("FAIL ovr_stat_drained: got %h want 00000004", d); else n_pass++;
  endtask
  task automatic test_tx;
    int w0, w1;
    txq.delete();
    wr(2'd0, 32'h55, w0);
    wr(2'd0, 32'hAA, w1);
    n_chk++; if (w0 + w1 !== 0) $display("FAIL tx_waits: got %0d want 0", w0 + w1); else n_pass++;
    for (int i = 0; i < 400 && txq.size() < 2; i++) cyc(1);
    cyc(60);
    n_chk++; if (txq.size() !== 2) $display("FAIL tx_starts: got %0d want 2", txq.size()); else n_pass++;
    n_chk++; if (txq[0] !== 8'h55) $display("FAIL tx_byte0: got %h want 55", txq[0]); else n_pass++;
    n_chk++; if (txq[1] !== 8'hAA) $display("FAIL tx_byte1: got %h want aa", txq[1]); else n_pass++;
    n_chk++; if (start_while_busy !== 0) $display("FAIL tx_start_busy: got %0d want 0", start_while_busy); else n_pass++;
  endtask
  task automatic test_backpressure;
    int w, wsum;
    logic [31:0] d;
    logic [7:0] exp;
    txq.delete();
    stall = 1;
    wsum = 0;
    for (int i = 0; i < 16; i++) begin
      wr(2'd0, 32'h60 + i, w);
      wsum += w;
    end
    n_chk++; if (wsum !== 0) $display("FAIL bp_fill_waits: got %0d want 0", wsum); else n_pass++;
    @(negedge clk);
    bus.enable = 1;
    bus.read_enable = 0;
    bus.addr = 2'd0;
    bus.data_save = 32'h70;
    #1;
    n_chk++; if (bus.busy !== 1'b1) $display("FAIL bp_busy_full: got %b want 1", bus.busy); else n_pass++;
    repeat (4) @(negedge clk);
    #1;
    n_chk++; if (bus.busy !== 1'b1) $display("FAIL bp_busy_held: got %b want 1", bus.busy); else n_pass++;
    stall = 0;
    #1;
    n_chk++; if (bus.busy !== 1'b0) $display("FAIL bp_busy_release: got %b want 0", bus.busy); else n_pass++;
    @(posedge clk);
    #1 bus.enable = 0;
    for (int i = 0; i < 1500 && txq.size() < 17; i++) cyc(1);
    cyc(60);
    n_chk++; if (txq.size() !== 17) $display("FAIL bp_count: got %0d want 17", txq.size()); else n_pass++;
    for (int i = 0; i < 17; i++) begin
      exp = (i < 16) ? 8'h60 + 8'(i) : 8'h70;
      n_chk++; if (txq[i] !== exp) $display("FAIL bp_byte%0d: got %h want %h", i, txq[i], exp); else n_pass++;
    end
    n_chk++; if (start_while_busy !== 0) $display("FAIL bp_start_busy: got %0d want 0", start_while_busy); else n_pass++;
    rd(2'd1, d);
    n_chk++; if (d !== 32'h4) $display("FAIL bp_stat_end: got %h want 00000004", d); else n_pass++;
  endtask
  task automatic test_interrupt;
    int w;
    logic [31:0] d;
    wr(2'd2, 32'h1, w);
    rx_pulse(8'h33);
    n_chk++; if (bus.intr !== 1'b0) $display("FAIL irq_latency: got %b want 0", bus.intr); else n_pass++;
    cyc(1);
    n_chk++; if (bus.intr !== 1'b1) $display("FAIL irq_rx: got %b want 1", bus.intr); else n_pass++;
    rd(2'd0, d);
    n_chk++; if (d !== 32'h33) $display("FAIL irq_data: got %h want 00000033", d); else n_pass++;
    cyc(1);
    n_chk++; if (bus.intr !== 1'b0) $display("FAIL irq_rx_clear: got %b want 0", bus.intr); else n_pass++;
    wr(2'd2, 32'h2, w);
    cyc(1);
    n_chk++; if (bus.intr !== 1'b1) $display("FAIL irq_tx_empty: got %b want 1", bus.intr); else n_pass++;
    rd(2'd2, d);
    n_chk++; if (d !== 32'h2) $display("FAIL irq_ier_read: got %h want 00000002", d); else n_pass++;
  endtask
  initial begin
    bus.enable = 0;
    bus.read_enable = 0;
    bus.addr = 0;
    bus.data_save = 0;
    bus.rxd_ready = 0;
    bus.rxd_data = 0;
    test_reset();
    test_rx();
    test_overrun();
    test_tx();
    test_backpressure();
    test_interrupt();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d passed so far", n_pass, n_chk);
    $fatal(1);
  end
endmodule
